// File: rtl/proc_pkg.sv
// Shared definitions for the small processor slice: memory geometry,
// opcode constants and the fetch-unit state type.
package proc_pkg;

   localparam int PROG_DEPTH = 16;
   localparam int IW         = 8;

   localparam logic [7:0] NOP = 8'h00;
   localparam logic [4:0] IN  = 5'b00111;
   localparam logic [4:0] ADD = 5'b01111;
   localparam logic [1:0] MOV = 2'b10;
   localparam logic [4:0] OUT = 5'b11111;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

endpackage

// File: rtl/instr_mem.sv
// Instruction store: one synchronous write port, one combinational read port.
// Deliberately has no reset so contents survive a fetch-unit reset.
module instr_mem #(
   parameter int DEPTH = 16,
   parameter int IW    = 8
) (
   input  logic                     clk,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_waddr,
   input  logic [IW-1:0]            i_wdata,
   input  logic [$clog2(DEPTH)-1:0] i_raddr,
   output logic [IW-1:0]            o_rdata
);

   logic [IW-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: loads a program while idle, then streams it
// word by word to the processor, honouring stall, and pulses done at the end.
module instr_fetch #(
   parameter int PROG_DEPTH = proc_pkg::PROG_DEPTH,
   parameter int IW         = proc_pkg::IW
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          load_en,
   input  logic [$clog2(PROG_DEPTH)-1:0] load_addr,
   input  logic [IW-1:0]                 load_data,
   input  logic [$clog2(PROG_DEPTH):0]   prog_len,
   input  logic                          start,
   input  logic                          stall,
   output logic [IW-1:0]                 I,
   output logic                          instr_valid,
   output logic [$clog2(PROG_DEPTH)-1:0] pc,
   output logic                          busy,
   output logic                          done
);

   import proc_pkg::*;

   localparam int ADDR_W = $clog2(PROG_DEPTH);
   localparam int LEN_W  = ADDR_W + 1;
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PROG_DEPTH);

   state_t           r_state, w_stateNext;
   logic [LEN_W-1:0] r_cnt, w_cntNext;
   logic [LEN_W-1:0] r_len, w_lenNext;
   logic [IW-1:0]    r_instr, w_instrNext;
   logic             r_valid, w_validNext;
   logic             r_busy, w_busyNext;
   logic             r_done, w_doneNext;

   logic             w_memWe;
   logic [IW-1:0]    w_memData;
   logic [LEN_W-1:0] w_lenClamp;

   assign w_memWe    = load_en && (r_state == S_IDLE);
   assign w_lenClamp = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;

   instr_mem #(
      .DEPTH (PROG_DEPTH),
      .IW    (IW)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_memWe),
      .i_waddr (load_addr),
      .i_wdata (load_data),
      .i_raddr (r_cnt[ADDR_W-1:0]),
      .o_rdata (w_memData)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_len   <= '0;
         r_instr <= IW'(NOP);
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_stateNext;
         r_cnt   <= w_cntNext;
         r_len   <= w_lenNext;
         r_instr <= w_instrNext;
         r_valid <= w_validNext;
         r_busy  <= w_busyNext;
         r_done  <= w_doneNext;
      end
   end

   // r_cnt counts issued words one bit wider than pc, so a full-depth program
   // still ends cleanly while pc itself wraps back to 0.
   always_comb begin
      w_stateNext = r_state;
      w_cntNext   = r_cnt;
      w_lenNext   = r_len;
      w_instrNext = r_instr;
      w_validNext = 1'b0;
      w_doneNext  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_instrNext = IW'(NOP);
            if (start && (prog_len != '0)) begin
               w_stateNext = S_RUN;
               w_cntNext   = '0;
               w_lenNext   = w_lenClamp;
            end
         end
         S_RUN: begin
            if (r_cnt == r_len) begin
               w_stateNext = S_DONE;
               w_instrNext = IW'(NOP);
               w_doneNext  = 1'b1;
            end else if (!stall) begin
               w_instrNext = w_memData;
               w_validNext = 1'b1;
               w_cntNext   = r_cnt + 1'b1;
            end
         end
         S_DONE: begin
            w_stateNext = S_IDLE;
            w_instrNext = IW'(NOP);
         end
         default: begin
            w_stateNext = S_IDLE;
            w_instrNext = IW'(NOP);
         end
      endcase
      w_busyNext = (w_stateNext == S_RUN);
   end

   assign I           = r_instr;
   assign instr_valid = r_valid;
   assign pc          = r_cnt[ADDR_W-1:0];
   assign busy        = r_busy;
   assign done        = r_done;

endmodule
